// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the ID-stage instruction fields and the hazard unit's responses.
//   master : pipeline/ID side. Drives the instruction fields and flush.
//            Receives stall, flush_id_ex, busy and stall_count.
//   slave  : the scoreboard. Sees the instruction and drives the responses.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int NUM_REGS    = 32,
    parameter int REG_AW      = 5,
    parameter int LAT_W       = 3,
    parameter int STALL_CNT_W = 32
);
    logic                   id_valid;
    logic [REG_AW-1:0]      id_rs1;
    logic [REG_AW-1:0]      id_rs2;
    logic                   id_rs1_used;
    logic                   id_rs2_used;
    logic                   id_is_store;
    logic [REG_AW-1:0]      id_rd;
    logic                   id_reg_wr;
    logic [LAT_W-1:0]       id_lat;
    logic                   flush;
    logic                   stall;
    logic                   flush_id_ex;
    logic [NUM_REGS-1:0]    busy;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_is_store, id_rd, id_reg_wr, id_lat, flush,
        input  stall, flush_id_ex, busy, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_is_store, id_rd, id_reg_wr, id_lat, flush,
        output stall, flush_id_ex, busy, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Per-register countdown scoreboard for the in-order pipeline. Each tracked
// register holds the number of cycles until its pending result can be
// forwarded. The ID instruction is stalled (with an ID/EX bubble) while a
// source, or a WAW destination, is still pending.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   sb         : hazard_scoreboard_if.slave
//                in : id_valid, id_rs1/2, id_rs1/2_used, id_is_store,
//                     id_rd, id_reg_wr, id_lat, flush
//                out: stall, flush_id_ex, busy, stall_count
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS        = 32,
    parameter int REG_AW          = 5,
    parameter int MAX_LAT         = 7,
    parameter int LAT_W           = 3,
    parameter bit STORE_LATE_DATA = 1'b1,
    parameter bit WAW_CHECK       = 1'b1,
    parameter int STALL_CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave sb
);

    logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q, cnt_d;
    logic [STALL_CNT_W-1:0]         stall_cnt_q, stall_cnt_d;
    logic [LAT_W-1:0]               lat_eff;
    logic [LAT_W-1:0]               c_rs1, c_rs2, c_rd;
    logic                           src_hz1, src_hz2, waw_hz;
    logic                           stall_w, issue;
    logic [NUM_REGS-1:0]            busy_w;

    // Out-of-range latencies saturate rather than wrap.
    assign lat_eff = (sb.id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : sb.id_lat;

    assign c_rs1 = cnt_q[sb.id_rs1];
    assign c_rs2 = cnt_q[sb.id_rs2];
    assign c_rd  = cnt_q[sb.id_rd];

    assign src_hz1 = sb.id_rs1_used && (sb.id_rs1 != '0) && (c_rs1 != '0);

    // Store data is consumed in MEM, so one extra pending cycle is tolerable
    // when late store data forwarding is enabled.
    assign src_hz2 = sb.id_rs2_used && (sb.id_rs2 != '0) &&
                     ((sb.id_is_store && STORE_LATE_DATA) ? (c_rs2 > LAT_W'(1))
                                                          : (c_rs2 != '0));

    // A younger write that would land before an older pending write to the
    // same rd would be clobbered by the older one.
    assign waw_hz = WAW_CHECK && sb.id_reg_wr && (sb.id_rd != '0) && (c_rd > lat_eff);

    // Flush dominates: a killed instruction neither stalls nor issues.
    assign stall_w = sb.id_valid && !sb.flush && (src_hz1 || src_hz2 || waw_hz);
    assign issue   = sb.id_valid && !stall_w && !sb.flush;

    assign sb.stall       = stall_w;
    assign sb.flush_id_ex = stall_w || sb.flush;
    assign sb.stall_count = stall_cnt_q;
    assign sb.busy        = busy_w;

    always_comb begin
        busy_w = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_w[r] = (cnt_q[r] != '0);
        end
    end

    // New issue to rd overrides the decrement of that register's counter.
    always_comb begin
        cnt_d    = cnt_q;
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (issue && sb.id_reg_wr && (sb.id_rd == REG_AW'(r))) begin
                cnt_d[r] = lat_eff;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
    end

    assign stall_cnt_d = (stall_w && (stall_cnt_q != '1)) ? stall_cnt_q + STALL_CNT_W'(1)
                                                          : stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard
// Two scoreboards see identical instruction streams: instance A with late
// store data and WAW checking enabled, instance B with both disabled. The
// reference model tracks, per register, the absolute cycle at which its
// result becomes forwardable; the remaining count is derived from that.
// Expected responses are queued by the driver and popped by a monitor on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard;
    localparam int NR = 32;
    localparam int AW = 5;
    localparam int LW = 3;
    localparam int ML = 7;
    localparam int SW = 32;

    typedef struct {
        logic          stall;
        logic          fid;
        logic [NR-1:0] busy;
        logic [SW-1:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NUM_REGS(NR), .REG_AW(AW), .LAT_W(LW), .STALL_CNT_W(SW)) ifa ();
    hazard_scoreboard_if #(.NUM_REGS(NR), .REG_AW(AW), .LAT_W(LW), .STALL_CNT_W(SW)) ifb ();

    hazard_scoreboard #(.NUM_REGS(NR), .REG_AW(AW), .MAX_LAT(ML), .LAT_W(LW),
                        .STORE_LATE_DATA(1'b1), .WAW_CHECK(1'b1), .STALL_CNT_W(SW))
        dut_a (.clk(clk), .rst_n(rst_n), .sb(ifa));

    hazard_scoreboard #(.NUM_REGS(NR), .REG_AW(AW), .MAX_LAT(ML), .LAT_W(LW),
                        .STORE_LATE_DATA(1'b0), .WAW_CHECK(1'b0), .STALL_CNT_W(SW))
        dut_b (.clk(clk), .rst_n(rst_n), .sb(ifb));

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   ready_at [2][NR];
    int unsigned sc_m [2];
    exp_t qa [$];
    exp_t qb [$];
    exp_t em;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            sc_m[k] = 0;
            for (int r = 0; r < NR; r++) ready_at[k][r] = 0;
        end
    endfunction

    // Instance k: 0 = late store data + WAW check, 1 = neither.
    function automatic exp_t model(int k, bit v, int r1, bit u1, int r2, bit u2,
                                   bit st, int rd, bit wr, int lat, bit fl);
        exp_t e;
        int rem [NR];
        bit h1, h2, hw, s;
        int l;
        l = (lat > ML) ? ML : lat;
        for (int r = 0; r < NR; r++) begin
            rem[r] = (r != 0 && ready_at[k][r] > cyc) ? ready_at[k][r] - cyc : 0;
            e.busy[r] = (rem[r] != 0);
        end
        h1 = u1 && r1 != 0 && rem[r1] != 0;
        h2 = u2 && r2 != 0 && ((st && k == 0) ? rem[r2] > 1 : rem[r2] != 0);
        hw = (k == 0) && wr && rd != 0 && rem[rd] > l;
        s  = v && !fl && (h1 || h2 || hw);
        e.stall = s;
        e.fid   = s || fl;
        e.sc    = sc_m[k];
        if (v && !s && !fl && wr && rd != 0) ready_at[k][rd] = cyc + 1 + l;
        if (s && sc_m[k] != 32'hFFFF_FFFF) sc_m[k]++;
        return e;
    endfunction

    task automatic set_ifs(bit v, int r1, bit u1, int r2, bit u2,
                           bit st, int rd, bit wr, int lat, bit fl);
        ifa.id_valid = v;  ifb.id_valid = v;
        ifa.id_rs1 = AW'(r1); ifb.id_rs1 = AW'(r1);
        ifa.id_rs2 = AW'(r2); ifb.id_rs2 = AW'(r2);
        ifa.id_rs1_used = u1; ifb.id_rs1_used = u1;
        ifa.id_rs2_used = u2; ifb.id_rs2_used = u2;
        ifa.id_is_store = st; ifb.id_is_store = st;
        ifa.id_rd = AW'(rd); ifb.id_rd = AW'(rd);
        ifa.id_reg_wr = wr; ifb.id_reg_wr = wr;
        ifa.id_lat = LW'(lat); ifb.id_lat = LW'(lat);
        ifa.flush = fl; ifb.flush = fl;
    endtask

    // One ID cycle: drive, queue expectations, advance past the edge.
    task automatic step(bit v, int r1, bit u1, int r2, bit u2,
                        bit st, int rd, bit wr, int lat, bit fl);
        set_ifs(v, r1, u1, r2, u2, st, rd, wr, lat, fl);
        qa.push_back(model(0, v, r1, u1, r2, u2, st, rd, wr, lat, fl));
        qb.push_back(model(1, v, r1, u1, r2, u2, st, rd, wr, lat, fl));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic nop(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (qa.size() > 0) begin
                em = qa.pop_front();
                chk("a.stall", 32'(ifa.stall), 32'(em.stall));
                chk("a.flush_id_ex", 32'(ifa.flush_id_ex), 32'(em.fid));
                chk("a.busy", ifa.busy, em.busy);
                chk("a.stall_count", ifa.stall_count, em.sc);
            end
            if (qb.size() > 0) begin
                em = qb.pop_front();
                chk("b.stall", 32'(ifb.stall), 32'(em.stall));
                chk("b.flush_id_ex", 32'(ifb.flush_id_ex), 32'(em.fid));
                chk("b.busy", ifb.busy, em.busy);
                chk("b.stall_count", ifb.stall_count, em.sc);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        set_ifs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        #2;
        chk("reset.a.busy", ifa.busy, 32'h0);
        chk("reset.a.stall_count", ifa.stall_count, 32'h0);
        chk("reset.b.busy", ifb.busy, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // load x5 lat 1 -> add rs1=x5 stalls once then issues
        step(1, 0, 0, 0, 0, 0, 5, 1, 1, 0);
        step(1, 5, 1, 0, 0, 0, 8, 1, 0, 0);
        step(1, 5, 1, 0, 0, 0, 8, 1, 0, 0);
        nop(1);
        // div x7 lat 5 -> consumer waits out the countdown
        step(1, 0, 0, 0, 0, 0, 7, 1, 5, 0);
        for (int i = 0; i < 6; i++) step(1, 7, 1, 0, 0, 0, 9, 1, 0, 0);
        nop(1);
        // store data after load: late-data mode hides the bubble
        step(1, 0, 0, 0, 0, 0, 5, 1, 1, 0);
        step(1, 2, 1, 5, 1, 1, 0, 0, 0, 0);
        step(1, 2, 1, 5, 1, 1, 0, 0, 0, 0);
        nop(1);
        // WAW on x3
        step(1, 0, 0, 0, 0, 0, 3, 1, 5, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0, 0, 3, 1, 0, 0);
        nop(6);
        // flush of a stalled instruction: its rd must not be recorded
        step(1, 0, 0, 0, 0, 0, 5, 1, 4, 0);
        step(1, 5, 1, 0, 0, 0, 9, 1, 3, 1);
        step(1, 5, 1, 0, 0, 0, 9, 1, 3, 0);
        // writes to x0 never tracked, and x0 sources never stall
        step(1, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        step(1, 0, 1, 0, 1, 0, 0, 1, 4, 0);
        nop(6);

        // asynchronous reset in the middle of a stall
        step(1, 0, 0, 0, 0, 0, 6, 1, 7, 0);
        set_ifs(1, 6, 1, 0, 0, 0, 10, 1, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset.a.busy", ifa.busy, 32'h0);
        chk("midreset.a.stall", 32'(ifa.stall), 32'h0);
        chk("midreset.a.stall_count", ifa.stall_count, 32'h0);
        chk("midreset.b.busy", ifb.busy, 32'h0);
        qa.delete();
        qb.delete();
        model_clear();
        set_ifs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;

        // random traffic over a small register pool to provoke hazards
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(9, 0) < 8,
                 $urandom_range(7, 0), $urandom_range(1, 0),
                 $urandom_range(7, 0), $urandom_range(1, 0),
                 $urandom_range(3, 0) == 0,
                 $urandom_range(7, 0), $urandom_range(3, 0) != 0,
                 $urandom_range(7, 0),
                 $urandom_range(9, 0) == 0);
        end
        nop(2);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
